vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator and successor to the fixed 640x480 sync block. It derives a pixel enable from the system clock by an integer divider and runs horizontal and vertical counters with fully configurable porch, sync and display lengths. It outputs sync pulses with selectable polarity, zero-skew video_on and coordinates, plus line and frame start strobes. It sits between the system clock and the pixel/character generators and the VGA connector.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels after display, before sync)
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (>=1)
HS_POL, 0, active level of hsync_o (0 = active low)
VS_POL, 0, active level of vsync_o (0 = active low)
CNT_W, 10, coordinate width; H_TOTAL and V_TOTAL must each be <= 2^CNT_W

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
enable_i  in  1  run enable; low freezes all timing state
hsync_o  out  1  horizontal sync, polarity HS_POL
vsync_o  out  1  vertical sync, polarity VS_POL
video_on_o  out  1  high while (x < H_DISPLAY) and (y < V_DISPLAY)
pixel_tick_o  out  1  one-clock strobe, last clock of each pixel period
line_start_o  out  1  pixel_tick_o and pixel_x_o == 0
frame_start_o  out  1  pixel_tick_o and pixel_x_o == 0 and pixel_y_o == 0
pixel_x_o  out  CNT_W  current horizontal count
pixel_y_o  out  CNT_W  current vertical count

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Defaults give 800 and 525.
- Line order: display, front porch, sync, back porch.
  - h sync active for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], defaults 656..751.
  - v sync active for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], defaults 490..491.
- Divider: div_cnt counts 0..CLK_DIV-1 while enable_i=1. pixel_tick = (div_cnt == CLK_DIV-1). With CLK_DIV=1, tick is high every enabled clock.
- enable_i=0:
  - div_cnt, x, y and all registered outputs hold their values.
  - pixel_tick_o, line_start_o and frame_start_o are forced low.
- Horizontal counter: on a clock edge with tick high, x wraps to 0 if x == H_TOTAL-1, otherwise x increments.
- Vertical counter: advances only on a tick edge where x == H_TOTAL-1. It wraps to 0 if y == V_TOTAL-1, otherwise y increments. Simultaneous h and v end wraps both to (0,0) on the same edge.
- hsync_o, vsync_o and video_on_o are registered. They are computed from the next-state counter values, so they are always the decode of the current pixel_x_o/pixel_y_o (zero skew, glitch-free).
- Strobes line_start_o and frame_start_o are combinational from registered state plus the tick, and are high exactly one clock per line/frame.
- Reset (asynchronous, any time, including mid-line or mid-sync):
  - div_cnt=0, x=0, y=0.
  - video_on_o=1, because (0,0) is visible.
  - hsync_o = ~HS_POL and vsync_o = ~VS_POL (inactive).
  - pixel_tick_o=0 unless CLK_DIV=1, in which case it is enable_i.
- First pixel period after reset release lasts CLK_DIV clocks. The first frame_start_o occurs on that first tick.
- Latency: a counter change and its sync/video_on decode are visible on the same clock edge.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV clocks (defaults: 840000).

Test Plan:
- Defaults, reset then run 2 frames -> frame_start_o spacing 840000 clk; line_start_o spacing 1600 clk; 525 line_starts per frame.
- Defaults, line scan -> hsync_o low exactly while x = 656..751 (192 clk); video_on_o high for x = 0..639 on y < 480 and never on y >= 480; vsync_o low only for y = 490..491.
- CLK_DIV=1, HS_POL=1, VS_POL=1, small timing (H 8/2/3/3, V 4/1/1/2, totals 16 and 8) -> frame period 128 clk; hsync_o high for x = 10..12; vsync_o high for y = 5; x/y wrap (15,7) -> (0,0) on the same edge.
- enable_i low for 37 clk mid-line at x=300 -> x, y, syncs and video_on hold; no ticks or strobes; counting resumes from x=300 with div_cnt intact.
- Assert reset_i asynchronously during hsync (x=700, y=200) -> immediately x=0, y=0, hsync_o=1, vsync_o=1, video_on_o=1; first tick 2 clk after release, with frame_start_o=1 on it.
- Check that hsync_o, vsync_o and video_on_o always equal the decode of the same-cycle pixel_x_o/pixel_y_o across a full frame (self-checking model, zero mismatches).

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-rate divider, horizontal and
// vertical counters, registered sync/video_on decode and line/frame strobes.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int CNT_W     = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             video_on_o,
  output logic             pixel_tick_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic [CNT_W-1:0] pixel_x_o,
  output logic [CNT_W-1:0] pixel_y_o
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  // A divide-by-one still needs a one-bit counter that simply stays at zero.
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic             HS_ACT   = (HS_POL != 0);
  localparam logic             VS_ACT   = (VS_POL != 0);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;
  logic             tick;
  logic             hs_next;
  logic             vs_next;
  logic             vo_next;

  // Next-state counters plus the sync/video decode of that next state, so the
  // registered decode always lines up with the registered coordinates.
  always_comb begin
    tick     = enable_i && (div_cnt == DIV_LAST);
    div_next = div_cnt;
    x_next   = x;
    y_next   = y;
    if (enable_i) begin
      div_next = tick ? '0 : div_cnt + DIV_W'(1);
    end
    if (tick) begin
      if (x == H_LAST) begin
        x_next = '0;
        y_next = (y == V_LAST) ? '0 : y + CNT_W'(1);
      end else begin
        x_next = x + CNT_W'(1);
      end
    end
    hs_next = ((x_next >= HS_FIRST) && (x_next <= HS_LAST)) ? HS_ACT : ~HS_ACT;
    vs_next = ((y_next >= VS_FIRST) && (y_next <= VS_LAST)) ? VS_ACT : ~VS_ACT;
    vo_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // Timing state register; reset lands on the visible origin with syncs idle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt    <= '0;
      x          <= '0;
      y          <= '0;
      hsync_o    <= ~HS_ACT;
      vsync_o    <= ~VS_ACT;
      video_on_o <= 1'b1;
    end else begin
      div_cnt    <= div_next;
      x          <= x_next;
      y          <= y_next;
      hsync_o    <= hs_next;
      vsync_o    <= vs_next;
      video_on_o <= vo_next;
    end
  end

  // Strobes are gated by the tick so they vanish whenever enable_i is low.
  always_comb begin
    pixel_tick_o  = tick;
    line_start_o  = tick && (x == '0);
    frame_start_o = tick && (x == '0) && (y == '0);
    pixel_x_o     = x;
    pixel_y_o     = y;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small 16x8 raster, divide-by-two,
// active-low hsync and active-high vsync.
module tb_vga_timing_gen;

  localparam int CLK_DIV    = 2;
  localparam int H_TOTAL    = 16;
  localparam int V_TOTAL    = 8;
  localparam int FRAME_CLKS = 256;
  localparam int LINE_CLKS  = 32;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic       hsync_o;
  logic       vsync_o;
  logic       video_on_o;
  logic       pixel_tick_o;
  logic       line_start_o;
  logic       frame_start_o;
  logic [3:0] pixel_x_o;
  logic [3:0] pixel_y_o;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .CLK_DIV(CLK_DIV), .HS_POL(0), .VS_POL(1), .CNT_W(4)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .enable_i(enable_i),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .video_on_o(video_on_o),
    .pixel_tick_o(pixel_tick_o),
    .line_start_o(line_start_o),
    .frame_start_o(frame_start_o),
    .pixel_x_o(pixel_x_o),
    .pixel_y_o(pixel_y_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       ls;
    logic       fs;
  } tick_state_t;

  tick_state_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int mx = 0;
  int my = 0;
  int mdiv = 0;
  int cyc = 0;
  int line_total = 0;
  int frame_cycs[$];
  int frame_lines[$];
  int line_cycs[$];

  // Expected outputs for a pixel position on this small raster.
  function automatic tick_state_t expectFor(input int px, input int py);
    tick_state_t e;
    e.x  = 4'(px);
    e.y  = 4'(py);
    e.hs = (px >= 10 && px <= 12) ? 1'b0 : 1'b1;
    e.vs = (py == 5) ? 1'b1 : 1'b0;
    e.vo = (px < 8) && (py < 4);
    e.ls = (px == 0);
    e.fs = (px == 0) && (py == 0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus; the expected tick response is queued up front.
  task automatic applyStimulus(input bit en, input bit rst);
    enable_i = en;
    reset_i  = rst;
    if (!rst && en && mdiv == CLK_DIV - 1) exp_q.push_back(expectFor(mx, my));
    @(posedge clk_i);
    if (rst) begin
      mx = 0; my = 0; mdiv = 0;
    end else if (en) begin
      if (mdiv == CLK_DIV - 1) begin
        mdiv = 0;
        if (mx == H_TOTAL - 1) begin
          mx = 0;
          my = (my == V_TOTAL - 1) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end else begin
        mdiv = mdiv + 1;
      end
    end
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_x"}, int'(pixel_x_o), 0);
    checkOutput({tag, "_y"}, int'(pixel_y_o), 0);
    checkOutput({tag, "_hsync"}, int'(hsync_o), 1);
    checkOutput({tag, "_vsync"}, int'(vsync_o), 0);
    checkOutput({tag, "_video_on"}, int'(video_on_o), 1);
    checkOutput({tag, "_tick"}, int'(pixel_tick_o), 0);
  endtask

  // Monitor: pop and compare on every tick, and watch strobe gating.
  always @(negedge clk_i) begin
    tick_state_t e;
    tick_state_t a;
    cyc++;
    checkOutput("strobe_gating", int'((line_start_o || frame_start_o) && !pixel_tick_o), 0);
    if (pixel_tick_o) begin
      a = {pixel_x_o, pixel_y_o, hsync_o, vsync_o, video_on_o, line_start_o, frame_start_o};
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_tick", int'(a), -1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("tick_state", int'(a), int'(e));
      end
    end
    if (frame_start_o) begin
      frame_cycs.push_back(cyc);
      frame_lines.push_back(line_total);
    end
    if (line_start_o) begin
      line_total++;
      line_cycs.push_back(cyc);
    end
  end

  initial begin
    bit found;
    reset_i  = 1'b1;
    enable_i = 1'b0;
    #12;
    checkResetState("reset");
    @(posedge clk_i);
    #1;

    // Two uninterrupted frames from reset release.
    for (int i = 0; i < 2 * FRAME_CLKS + 8; i++) applyStimulus(1'b1, 1'b0);
    if (frame_cycs.size() >= 2 && line_cycs.size() >= 2) begin
      checkOutput("frame_period", frame_cycs[1] - frame_cycs[0], FRAME_CLKS);
      checkOutput("lines_per_frame", frame_lines[1] - frame_lines[0], V_TOTAL);
      checkOutput("line_period", line_cycs[1] - line_cycs[0], LINE_CLKS);
    end else begin
      checkOutput("frame_starts_seen", frame_cycs.size(), 2);
    end

    // Freeze for 37 clocks mid-line with the divider half way through a pixel.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (mx == 5 && mdiv == 1) found = 1'b1;
      else applyStimulus(1'b1, 1'b0);
    end
    checkOutput("reach_x5", int'(found), 1);
    for (int i = 0; i < 37; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("hold_x", int'(pixel_x_o), 5);
    checkOutput("hold_y", int'(pixel_y_o), my);
    checkOutput("hold_hsync", int'(hsync_o), 1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0);

    // Asynchronous reset in the middle of hsync, between clock edges.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (mx == 11 && mdiv == 0) found = 1'b1;
      else applyStimulus(1'b1, 1'b0);
    end
    checkOutput("reach_x11", int'(found), 1);
    checkOutput("in_hsync", int'(hsync_o), 0);
    #2;
    reset_i = 1'b1;
    #1;
    mx = 0; my = 0; mdiv = 0;
    checkResetState("async_reset");
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < FRAME_CLKS; i++) applyStimulus(1'b1, 1'b0);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
